// File: rtl/alu_flags.sv
// Multi-cycle ALU stage with Z/N condition flags and a start/busy/done handshake.
// ADD/SUB/AND finish in one EXEC cycle; ASR shifts one bit per EXEC cycle.
module alu_flags #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [2:0]   shamt,
    input  logic         flag_ld,
    input  logic [N-1:0] flag_data,
    output logic [N-1:0] result,
    output logic         busy,
    output logic         done,
    output logic         z,
    output logic         n
);

    typedef enum logic {IDLE, EXEC} state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_ASR = 2'b11;

    state_t       state_q, state_d;
    logic [1:0]   op_q, op_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [N-1:0] work_q, work_d;
    logic [N-1:0] result_q, result_d;
    logic [2:0]   shamt_q, shamt_d;
    logic [2:0]   cnt_q, cnt_d;
    logic         z_q, z_d;
    logic         n_q, n_d;
    logic         done_q, done_d;

    logic         is_sub;
    logic [N-1:0] adder_b;
    logic [N-1:0] sum;
    logic [N-1:0] shifted;
    logic [N-1:0] alu_val;

    // SUB reuses the adder as A + ~B + 1; a zero shift count means the lone EXEC cycle passes A through.
    always_comb begin
        is_sub  = (op_q == OP_SUB);
        adder_b = is_sub ? ~b_q : b_q;
        sum     = a_q + adder_b + {{(N-1){1'b0}}, is_sub};
        shifted = (shamt_q != 3'd0) ? {work_q[N-1], work_q[N-1:1]} : work_q;
        case (op_q)
            OP_ADD:  alu_val = sum;
            OP_SUB:  alu_val = sum;
            OP_AND:  alu_val = a_q & b_q;
            default: alu_val = shifted;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        shamt_d  = shamt_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        z_d      = z_q;
        n_d      = n_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = in_a;
                    b_d     = in_b;
                    shamt_d = shamt;
                    work_d  = in_a;
                    cnt_d   = (op == OP_ASR && shamt != 3'd0) ? shamt : 3'd1;
                    state_d = EXEC;
                end else if (flag_ld) begin
                    z_d = (flag_data == '0);
                    n_d = flag_data[N-1];
                end
            end
            default: begin
                cnt_d  = cnt_q - 3'd1;
                work_d = shifted;
                if (cnt_q == 3'd1) begin
                    result_d = alu_val;
                    z_d      = (alu_val == '0);
                    n_d      = alu_val[N-1];
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            shamt_q  <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            shamt_q  <= shamt_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            z_q      <= z_d;
            n_q      <= n_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q == EXEC);
    assign done   = done_q;
    assign z      = z_q;
    assign n      = n_q;

endmodule

// File: tb/tb_alu_flags.sv
// Self-checking bench for alu_flags: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_alu_flags;

    localparam int N = 8;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_ASR = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = '0;
    logic [N-1:0] in_a = '0;
    logic [N-1:0] in_b = '0;
    logic [2:0]   shamt = '0;
    logic         flag_ld = 1'b0;
    logic [N-1:0] flag_data = '0;
    logic [N-1:0] result;
    logic         busy;
    logic         done;
    logic         z;
    logic         n;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    int       m_left = 0;
    logic [7:0] m_result = '0;
    logic [7:0] m_pending = '0;
    logic     m_z = 1'b0;
    logic     m_n = 1'b0;
    logic     m_done = 1'b0;

    alu_flags #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .in_a(in_a), .in_b(in_b),
        .shamt(shamt), .flag_ld(flag_ld), .flag_data(flag_data), .result(result),
        .busy(busy), .done(done), .z(z), .n(n)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] refAlu(input logic [1:0] o, input logic [7:0] a,
                                          input logic [7:0] b, input logic [2:0] sh);
        int sa;
        case (o)
            OP_ADD: return 8'((int'(a) + int'(b)) % 256);
            OP_SUB: return 8'((int'(a) - int'(b) + 256) % 256);
            OP_AND: return a & b;
            default: begin
                sa = int'(a);
                if (sa > 127) sa = sa - 256;
                return 8'(sa >>> sh);
            end
        endcase
    endfunction

    // Reference timing: an accepted op completes L edges later; requests while busy are dropped.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left   <= 0;
            m_result <= '0;
            m_z      <= 1'b0;
            m_n      <= 1'b0;
            m_done   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_result <= m_pending;
                    m_z      <= (m_pending == 8'h00);
                    m_n      <= m_pending[7];
                    m_done   <= 1'b1;
                end
            end else if (start) begin
                m_pending <= refAlu(op, in_a, in_b, shamt);
                m_left    <= (op == OP_ASR && shamt != 3'd0) ? int'(shamt) : 1;
            end else if (flag_ld) begin
                m_z <= (flag_data == 8'h00);
                m_n <= flag_data[7];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("model_result", 32'(result), 32'(m_result));
            checkOutput("model_z", 32'(z), 32'(m_z));
            checkOutput("model_n", 32'(n), 32'(m_n));
            checkOutput("model_busy", 32'(busy), 32'(m_left > 0));
            checkOutput("model_done", 32'(done), 32'(m_done));
        end
    end

    task automatic applyStimulus(input logic s, input logic [1:0] o, input logic [7:0] a,
                                 input logic [7:0] b, input logic [2:0] sh,
                                 input logic fl, input logic [7:0] fd);
        start = s; op = o; in_a = a; in_b = b; shamt = sh; flag_ld = fl; flag_data = fd;
        @(negedge clk);
    endtask

    // Idle cycles scramble operands so latched values are the only ones that can matter.
    task automatic idleCycle();
        applyStimulus(1'b0, 2'($urandom), 8'($urandom), 8'($urandom), 3'($urandom), 1'b0, 8'($urandom));
    endtask

    task automatic waitDone(input int k0, output int k);
        k = k0;
        while (!done && k < 20) begin
            idleCycle();
            k++;
        end
        if (k >= 20) checkOutput("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic runOp(input string name, input logic [1:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] sh, input logic [7:0] er,
                         input logic ez, input logic en, input int el);
        int k;
        applyStimulus(1'b1, o, a, b, sh, 1'b0, 8'h00);
        waitDone(0, k);
        checkOutput({name, "_latency"}, 32'(k), 32'(el));
        checkOutput({name, "_result"}, 32'(result), 32'(er));
        checkOutput({name, "_z"}, 32'(z), 32'(ez));
        checkOutput({name, "_n"}, 32'(n), 32'(en));
        checkOutput({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation did not end, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int  k;
        bit  saw_done;
        repeat (2) @(negedge clk);
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_z", 32'(z), 32'd0);
        checkOutput("reset_n", 32'(n), 32'd0);
        cmp_en = 1'b1;
        rst_n  = 1'b1;
        idleCycle();

        runOp("add_5_1", OP_ADD, 8'd5, 8'd1, 3'd0, 8'd6, 1'b0, 1'b0, 1);
        runOp("add_wrap", OP_ADD, 8'd255, 8'd2, 3'd0, 8'd1, 1'b0, 1'b0, 1);
        runOp("sub_9_9", OP_SUB, 8'd9, 8'd9, 3'd0, 8'd0, 1'b1, 1'b0, 1);
        runOp("sub_1_2", OP_SUB, 8'd1, 8'd2, 3'd0, 8'hFF, 1'b0, 1'b1, 1);
        runOp("add_pre", OP_ADD, 8'h10, 8'h20, 3'd0, 8'h30, 1'b0, 1'b0, 1);
        runOp("and_b2b", OP_AND, 8'hF0, 8'h0F, 3'd0, 8'h00, 1'b1, 1'b0, 1);

        applyStimulus(1'b1, OP_ASR, 8'h80, 8'h00, 3'd3, 1'b0, 8'h00);
        checkOutput("asr3_busy", 32'(busy), 32'd1);
        applyStimulus(1'b1, OP_ADD, 8'd1, 8'd1, 3'd0, 1'b0, 8'h00);
        waitDone(1, k);
        checkOutput("asr3_latency", 32'(k), 32'd3);
        checkOutput("asr3_result", 32'(result), 32'hF0);
        checkOutput("asr3_n", 32'(n), 32'd1);
        idleCycle();
        checkOutput("asr3_noqueue_busy", 32'(busy), 32'd0);
        checkOutput("asr3_noqueue_done", 32'(done), 32'd0);

        runOp("asr0", OP_ASR, 8'h5A, 8'h00, 3'd0, 8'h5A, 1'b0, 1'b0, 1);
        runOp("asr7_neg", OP_ASR, 8'h81, 8'h00, 3'd7, 8'hFF, 1'b0, 1'b1, 7);
        runOp("asr7_pos", OP_ASR, 8'h7F, 8'h00, 3'd7, 8'h00, 1'b1, 1'b0, 7);
        runOp("asr2", OP_ASR, 8'hB4, 8'h00, 3'd2, 8'hED, 1'b0, 1'b1, 2);
        runOp("add_42", OP_ADD, 8'h40, 8'h02, 3'd0, 8'h42, 1'b0, 1'b0, 1);

        applyStimulus(1'b0, OP_ADD, 8'h00, 8'h00, 3'd0, 1'b1, 8'h00);
        checkOutput("fld0_z", 32'(z), 32'd1);
        checkOutput("fld0_n", 32'(n), 32'd0);
        checkOutput("fld0_result", 32'(result), 32'h42);
        checkOutput("fld0_done", 32'(done), 32'd0);
        applyStimulus(1'b0, OP_ADD, 8'h00, 8'h00, 3'd0, 1'b1, 8'h80);
        checkOutput("fld80_z", 32'(z), 32'd0);
        checkOutput("fld80_n", 32'(n), 32'd1);
        applyStimulus(1'b0, OP_ADD, 8'h00, 8'h00, 3'd0, 1'b1, 8'h00);
        applyStimulus(1'b1, OP_ADD, 8'd3, 8'd4, 3'd0, 1'b1, 8'h80);
        checkOutput("startfld_z_held", 32'(z), 32'd1);
        checkOutput("startfld_n_held", 32'(n), 32'd0);
        idleCycle();
        checkOutput("startfld_done", 32'(done), 32'd1);
        checkOutput("startfld_result", 32'(result), 32'd7);
        checkOutput("startfld_n", 32'(n), 32'd0);

        runOp("add_80", OP_ADD, 8'h7F, 8'h01, 3'd0, 8'h80, 1'b0, 1'b1, 1);
        applyStimulus(1'b1, OP_ASR, 8'h80, 8'h00, 3'd5, 1'b0, 8'h00);
        idleCycle();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_result", 32'(result), 32'd0);
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_done", 32'(done), 32'd0);
        checkOutput("rst_mid_z", 32'(z), 32'd0);
        checkOutput("rst_mid_n", 32'(n), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (8) begin
            idleCycle();
            if (done) saw_done = 1'b1;
        end
        checkOutput("rst_no_done", 32'(saw_done), 32'd0);
        runOp("add_after_rst", OP_ADD, 8'd2, 8'd3, 3'd0, 8'd5, 1'b0, 1'b0, 1);

        repeat (400) begin
            applyStimulus(($urandom_range(0, 1) == 1), 2'($urandom), 8'($urandom), 8'($urandom),
                          3'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom));
        end
        repeat (10) idleCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
